// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 packet transmitter.
//   state_t       - packet sequencer states
//   FRAME_BITS    - bits per PS/2 frame (start, 8 data, parity, stop)
//   BYTES_PER_PKT - bytes per packet
//   build_frame() - assembles one frame, bit 0 first on the wire
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam int   FRAME_BITS    = 11;
  localparam int   BYTES_PER_PKT = 3;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

  // Index 0 is the start bit, data LSB first, then odd parity, then stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] b);
    return {STOP_BIT, ~^b, b, START_BIT};
  endfunction
endpackage

// File: rtl/ps2_packet_tx_if.sv
// ps2_packet_tx_if: packet handshake plus PS/2 line and status signals.
//   pkt_in/pkt_valid/pkt_ready - 24-bit packet handshake
//   ps2_clk_out/ps2_data_out   - PS/2 lines, idle high
//   busy/done                  - transmit status
//   master: packet source side; slave: transmitter side
interface ps2_packet_tx_if;
  logic [23:0] pkt_in;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        ps2_clk_out;
  logic        ps2_data_out;
  logic        busy;
  logic        done;

  modport master (output pkt_in, pkt_valid,
                  input  pkt_ready, ps2_clk_out, ps2_data_out, busy, done);
  modport slave  (input  pkt_in, pkt_valid,
                  output pkt_ready, ps2_clk_out, ps2_data_out, busy, done);
endinterface

// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx: serializes one byte as an 11-bit PS/2 frame.
//   clk, reset     - system clock, async active-high reset
//   i_start        - load i_byte and begin a frame (wins over a finishing frame)
//   i_byte         - byte to send
//   o_ps2_clk      - registered PS/2 clock, high first half of each bit
//   o_ps2_data     - registered PS/2 data, held for the whole bit
//   o_frame_done   - combinational, high in the last cycle of the stop bit
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_ps2_clk,
  output logic       o_ps2_data,
  output logic       o_frame_done
);
  localparam int DIV_W    = $clog2(2*CLK_DIV);
  localparam int DIV_LAST = 2*CLK_DIV - 1;

  logic                  r_active, w_active_n;
  logic [3:0]            r_bit, w_bit_n;
  logic [DIV_W-1:0]      r_div, w_div_n;
  logic [FRAME_BITS-1:0] r_frame, w_frame_n;
  logic                  r_clk, r_dat;
  logic                  w_bit_end, w_clk_n, w_dat_n;

  assign w_bit_end    = r_active && (r_div == DIV_W'(DIV_LAST));
  assign o_frame_done = w_bit_end && (r_bit == 4'(FRAME_BITS-1));

  always_comb begin
    w_active_n = r_active;
    w_bit_n    = r_bit;
    w_div_n    = r_div;
    w_frame_n  = r_frame;
    if (i_start) begin
      w_active_n = 1'b1;
      w_bit_n    = '0;
      w_div_n    = '0;
      w_frame_n  = build_frame(i_byte);
    end else if (r_active) begin
      if (w_bit_end) begin
        w_div_n = '0;
        if (o_frame_done) begin
          w_active_n = 1'b0;
          w_bit_n    = '0;
        end else begin
          w_bit_n = r_bit + 4'd1;
        end
      end else begin
        w_div_n = r_div + DIV_W'(1);
      end
    end
    // Lines are registered from the next-state counters so they change
    // on the same edge the counters do.
    w_dat_n = w_active_n ? w_frame_n[w_bit_n] : 1'b1;
    w_clk_n = w_active_n ? (w_div_n < DIV_W'(CLK_DIV)) : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active <= 1'b0;
      r_bit    <= '0;
      r_div    <= '0;
      r_frame  <= '1;
      r_clk    <= 1'b1;
      r_dat    <= 1'b1;
    end else begin
      r_active <= w_active_n;
      r_bit    <= w_bit_n;
      r_div    <= w_div_n;
      r_frame  <= w_frame_n;
      r_clk    <= w_clk_n;
      r_dat    <= w_dat_n;
    end
  end

  assign o_ps2_clk  = r_clk;
  assign o_ps2_data = r_dat;
endmodule

// File: rtl/ps2_packet_tx.sv
// ps2_packet_tx: sends a 24-bit packet as three PS/2 frames, MSB byte first,
// with GAP_BITS idle bit-periods between bytes.
//   clk, reset - system clock, async active-high reset
//   bus        - slave side of ps2_packet_tx_if (handshake, lines, busy/done)
module ps2_packet_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  ps2_packet_tx_if.slave  bus
);
  localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t           r_state, w_state_n;
  logic [1:0]       r_byte_idx, w_byte_n;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_n;
  logic [23:0]      r_pkt, w_pkt_n;
  logic             r_done, r_busy, w_done_n;
  logic             w_start, w_frame_done;
  logic [7:0]       w_start_byte;

  ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_start),
    .i_byte       (w_start_byte),
    .o_ps2_clk    (bus.ps2_clk_out),
    .o_ps2_data   (bus.ps2_data_out),
    .o_frame_done (w_frame_done)
  );

  // r_pkt holds the not-yet-sent bytes left-aligned; each frame start
  // consumes the top byte and shifts the rest up.
  always_comb begin
    w_state_n    = r_state;
    w_byte_n     = r_byte_idx;
    w_gap_n      = r_gap_cnt;
    w_pkt_n      = r_pkt;
    w_done_n     = 1'b0;
    w_start      = 1'b0;
    w_start_byte = r_pkt[23:16];
    case (r_state)
      IDLE: begin
        if (bus.pkt_valid) begin
          w_start      = 1'b1;
          w_start_byte = bus.pkt_in[23:16];
          w_pkt_n      = {bus.pkt_in[15:0], 8'h00};
          w_byte_n     = '0;
          w_state_n    = SEND;
        end
      end
      SEND: begin
        if (w_frame_done) begin
          if (r_byte_idx == 2'(BYTES_PER_PKT-1)) begin
            w_state_n = IDLE;
            w_done_n  = 1'b1;
          end else if (GAP_CYC == 0) begin
            w_start  = 1'b1;
            w_pkt_n  = {r_pkt[15:0], 8'h00};
            w_byte_n = r_byte_idx + 2'd1;
          end else begin
            w_state_n = GAP;
            w_gap_n   = '0;
          end
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYC-1)) begin
          w_start   = 1'b1;
          w_pkt_n   = {r_pkt[15:0], 8'h00};
          w_byte_n  = r_byte_idx + 2'd1;
          w_state_n = SEND;
        end else begin
          w_gap_n = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_byte_idx <= '0;
      r_gap_cnt  <= '0;
      r_pkt      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_byte_idx <= w_byte_n;
      r_gap_cnt  <= w_gap_n;
      r_pkt      <= w_pkt_n;
      r_done     <= w_done_n;
      r_busy     <= (w_state_n != IDLE);
    end
  end

  assign bus.pkt_ready = (r_state == IDLE);
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule
